// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch initiator.
// Holds the program counter and drives the instruction ROM, which is read
// combinationally. Fetched words land in a small registered prefetch FIFO
// that feeds decode. Execute can redirect the fetch stream at any time.
//
// Decode handshake: the head entry transfers on a cycle where
// id_valid_o && id_ready_i. id_valid_o never depends on id_ready_i, and the
// head is held stable until it is accepted or flushed by a redirect.
//
// Optional feature: define IF_MISALIGN_CHECK_EN to get a one-cycle
// misalign_o pulse after a redirect whose target has nonzero bits [2:0].
// Without it, misalign_o is tied to 0. The target's low bits are dropped in
// both builds.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o,
    input  logic              id_ready_i,
    output logic              misalign_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              run;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;

    // A slot frees up in the same cycle decode pops, so a full FIFO keeps
    // streaming at one instruction per cycle.
    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o && id_ready_i;
    assign rom_ce     = run && !redirect_i && ((count < CNT_W'(DEPTH)) || pop);
    assign push       = rom_ce;
    assign rom_addr   = pc;
    assign id_inst_o  = inst_mem[rd_ptr];
    assign id_pc_o    = pc_mem[rd_ptr];

    // Fetch is held off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // PC, pointers and occupancy; a redirect flushes everything and wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            pc     <= redirect_pc_i & ~ADDR_W'(7);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(8);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // FIFO storage: each entry keeps the instruction and the PC it came from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= rom_inst;
            pc_mem[wr_ptr]   <= pc;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;

    // Registered pulse flagging a redirect target that was not 8-byte aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i && (redirect_pc_i[2:0] != 3'b000);
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule
